// File: rtl/traffic_state_seq.sv
// traffic_state_seq -- phase sequencer for a main-road / side-road junction
// with a pedestrian all-red phase.
//
// A prescaler divides clk down to a one-second tick. Each phase lasts a fixed
// number of ticks. At the end of a phase the next phase is chosen from the
// side-road sensor (sampled at the end of the green phases 000/100 only) and
// from a latched walk request (sampled at the end of main yellow 011).
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sensor       in   side-road traffic present (level)
//   walk_btn     in   pedestrian request (level or pulse)
//   state        out  [2:0] current phase code, registered
//   sec_left     out  [2:0] seconds remaining in the current phase, registered
//   walk_pending out  latched walk request not yet served, registered
//   tick         out  one-cycle pulse on each second boundary, registered
module traffic_state_seq #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic       walk_btn,
  output logic [2:0] state,
  output logic [2:0] sec_left,
  output logic       walk_pending,
  output logic       tick
);

  localparam int unsigned DIV_W = (TICK_DIV > 32'd2) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 32'd1);
  // One count before the last: lets tick be a register that is high exactly
  // while div == TICK_DIV-1.
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(TICK_DIV - 32'd2);

  typedef enum logic [2:0] {
    S_MAIN_GREEN  = 3'b000,
    S_MAIN_EXT    = 3'b001,
    S_MAIN_LONG   = 3'b010,
    S_MAIN_YELLOW = 3'b011,
    S_SIDE_GREEN  = 3'b100,
    S_SIDE_EXT    = 3'b101,
    S_SIDE_YELLOW = 3'b110,
    S_WALK        = 3'b111
  } phase_t;

  // Phase length in ticks.
  function automatic logic [2:0] phase_dur(input phase_t p);
    case (p)
      S_MAIN_GREEN:  phase_dur = 3'd6;
      S_MAIN_EXT:    phase_dur = 3'd3;
      S_MAIN_LONG:   phase_dur = 3'd6;
      S_MAIN_YELLOW: phase_dur = 3'd2;
      S_SIDE_GREEN:  phase_dur = 3'd6;
      S_SIDE_EXT:    phase_dur = 3'd3;
      S_SIDE_YELLOW: phase_dur = 3'd2;
      S_WALK:        phase_dur = 3'd3;
      default:       phase_dur = 3'd6;
    endcase
  endfunction

  phase_t           state_r, state_next_s;
  logic [2:0]       cnt_r, cnt_next_s;
  logic [DIV_W-1:0] div_r, div_next_s;
  logic             tick_r, tick_next_s, tick_now_s;
  logic             walk_r, walk_next_s, walk_eff_s;
  logic [2:0]       sec_left_r, sec_left_next_s;

  // Next-state, prescaler, phase counter and walk-latch logic.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    div_next_s      = div_r;
    tick_now_s      = (div_r == DIV_LAST);
    tick_next_s     = (div_r == DIV_PRE);
    // A press in the same cycle as the 011 ending tick must already count,
    // so the routing decision looks at the press as well as the latch.
    // Presses during the walk phase itself are dropped.
    walk_eff_s      = walk_r | (walk_btn & (state_r != S_WALK));
    walk_next_s     = walk_eff_s;
    sec_left_next_s = sec_left_r;

    if (tick_now_s) begin
      div_next_s = {DIV_W{1'b0}};
    end else begin
      div_next_s = div_r + DIV_W'(1);
    end

    if (tick_now_s) begin
      // >= rather than == so a corrupted counter still ends the phase.
      if (cnt_r >= (phase_dur(state_r) - 3'd1)) begin
        cnt_next_s = 3'd0;
        case (state_r)
          S_MAIN_GREEN:  state_next_s = sensor ? S_MAIN_EXT : S_MAIN_LONG;
          S_MAIN_EXT:    state_next_s = S_MAIN_YELLOW;
          S_MAIN_LONG:   state_next_s = S_MAIN_YELLOW;
          S_MAIN_YELLOW: state_next_s = walk_eff_s ? S_WALK : S_SIDE_GREEN;
          S_SIDE_GREEN:  state_next_s = sensor ? S_SIDE_EXT : S_SIDE_YELLOW;
          S_SIDE_EXT:    state_next_s = S_SIDE_YELLOW;
          S_SIDE_YELLOW: state_next_s = S_MAIN_GREEN;
          S_WALK:        state_next_s = S_SIDE_GREEN;
          default: begin
            state_next_s = S_MAIN_GREEN;
            cnt_next_s   = 3'd0;
          end
        endcase
      end else begin
        cnt_next_s = cnt_r + 3'd1;
      end
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
    end

    // Entering the walk phase serves the request; this beats a coincident press.
    if ((state_next_s == S_WALK) && (state_r != S_WALK)) begin
      walk_next_s = 1'b0;
    end else begin
      walk_next_s = walk_eff_s;
    end

    sec_left_next_s = phase_dur(state_next_s) - cnt_next_s;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_MAIN_GREEN;
      cnt_r      <= 3'd0;
      div_r      <= {DIV_W{1'b0}};
      tick_r     <= 1'b0;
      walk_r     <= 1'b0;
      sec_left_r <= 3'd6;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      div_r      <= div_next_s;
      tick_r     <= tick_next_s;
      walk_r     <= walk_next_s;
      sec_left_r <= sec_left_next_s;
    end
  end

  assign state        = state_r;
  assign sec_left     = sec_left_r;
  assign walk_pending = walk_r;
  assign tick         = tick_r;

endmodule

// File: tb/tb_traffic_state_seq.sv
// Testbench for traffic_state_seq with TICK_DIV=4. A behavioural model built
// from the phase table (durations, successor choices, walk-latch rules)
// predicts every output each cycle; scenario tasks add explicit checks on
// phase lengths and on the boundary cases.
module tb_traffic_state_seq;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_btn = 1'b0;
  logic [2:0] state;
  logic [2:0] sec_left;
  logic       walk_pending;
  logic       tick;

  int errors = 0;
  int checks = 0;

  traffic_state_seq #(.TICK_DIV(TD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor       (sensor),
    .walk_btn     (walk_btn),
    .state        (state),
    .sec_left     (sec_left),
    .walk_pending (walk_pending),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, ticks elapsed in phase, cycles into second.
  int dur [8] = '{6, 3, 6, 2, 6, 3, 2, 3};
  int m_state, m_cnt, m_div;
  bit m_pend;

  function automatic int m_next(input int s, input bit sen, input bit wk);
    case (s)
      0:       return sen ? 1 : 2;
      1, 2:    return 3;
      3:       return wk ? 7 : 4;
      4:       return sen ? 5 : 6;
      5:       return 6;
      6:       return 0;
      7:       return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_div = 0; m_pend = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit pend_eff;
    bit entered_walk;
    int ns;
    entered_walk = 1'b0;
    pend_eff = m_pend | (walk_btn && (m_state != 7));
    if (m_div == TD - 1) begin
      if (m_cnt == dur[m_state] - 1) begin
        ns = m_next(m_state, sensor, pend_eff);
        entered_walk = (ns == 7);
        m_state = ns;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_pend = entered_walk ? 1'b0 : pend_eff;
    m_div = (m_div + 1) % TD;
  endtask

  function automatic logic [7:0] exp_vec();
    return {3'(m_state), 3'(dur[m_state] - m_cnt), m_pend, (m_div == TD - 1)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Assert reset between edges, check the asynchronous effect, then release.
  task automatic apply_reset(input string nm);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, sec_left, walk_pending, tick} !== 8'b000_110_0_0) begin
      errors++;
      $display("FAIL %s async_reset: got=%b want=%b", nm,
               {state, sec_left, walk_pending, tick}, 8'b000_110_0_0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    walk_btn = 1'b1;
    sensor = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({state, sec_left, walk_pending, tick} !== 8'b000_110_0_0) begin
        errors++;
        $display("FAIL reset_hold: got=%b want=%b",
                 {state, sec_left, walk_pending, tick}, 8'b000_110_0_0);
      end
    end
    walk_btn = 1'b0;
    sensor = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Run from reset with fixed sensor and an optional one-cycle press, then
  // compare the observed phase run lengths with the expected table.
  task automatic test_phase_sequence(input string nm, input bit sen, input int walk_at,
                                     input int exp_s[7], input int exp_l[7], input int nph);
    int got_s [16];
    int got_l [16];
    int k, n, cur, total;
    apply_reset(nm);
    for (int j = 0; j < 16; j++) begin got_s[j] = -1; got_l[j] = -1; end
    total = 0;
    for (int j = 0; j < nph; j++) total += exp_l[j];
    sensor = sen;
    k = 0; n = 1; cur = int'(state);
    for (int i = 0; i < total + 4; i++) begin
      walk_btn = (i == walk_at);
      step();
      checks++;
      if ({state, sec_left, walk_pending, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL %s cycle %0d: got=%b want=%b", nm, i,
                 {state, sec_left, walk_pending, tick}, exp_vec());
      end
      if (int'(state) == cur) begin
        n++;
      end else begin
        if (k < 16) begin got_s[k] = cur; got_l[k] = n; k++; end
        cur = int'(state);
        n = 1;
      end
    end
    walk_btn = 1'b0;
    for (int j = 0; j < nph; j++) begin
      checks++;
      if (got_s[j] !== exp_s[j] || got_l[j] !== exp_l[j]) begin
        errors++;
        $display("FAIL %s phase %0d: got state %0d for %0d clk, want state %0d for %0d clk",
                 nm, j, got_s[j], got_l[j], exp_s[j], exp_l[j]);
      end
    end
    checks++;
    if (cur !== 0) begin
      errors++;
      $display("FAIL %s return: got state %0d want 0", nm, cur);
    end
  endtask

  task automatic test_no_traffic();
    int s [7];
    int l [7];
    s = '{0, 2, 3, 4, 6, 0, 0};
    l = '{24, 24, 8, 24, 8, 0, 0};
    test_phase_sequence("no_traffic", 1'b0, -1, s, l, 5);
  endtask

  task automatic test_sensor_held();
    int s [7];
    int l [7];
    s = '{0, 1, 3, 4, 5, 6, 0};
    l = '{24, 12, 8, 24, 12, 8, 0};
    test_phase_sequence("sensor_held", 1'b1, -1, s, l, 6);
  endtask

  task automatic test_walk_served();
    int s [7];
    int l [7];
    s = '{0, 2, 3, 7, 4, 6, 0};
    l = '{24, 24, 8, 12, 24, 8, 0};
    test_phase_sequence("walk_served", 1'b0, 5, s, l, 6);
  endtask

  task automatic test_walk_on_end();
    int guard;
    apply_reset("walk_on_end");
    sensor = 1'b0;
    guard = 0;
    // Stop on the cycle whose closing edge ends phase 011.
    while (!(m_state == 3 && m_div == TD - 1 && m_cnt == dur[3] - 1) && guard < 200) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL walk_on_end timeout: got %0d cycles want <200", guard);
    end
    walk_btn = 1'b1;
    step();
    checks++;
    if ({state, walk_pending} !== 4'b111_0) begin
      errors++;
      $display("FAIL walk_on_end enter: got state=%b pend=%b want 111/0", state, walk_pending);
    end
    guard = 0;
    while (state == 3'b111 && guard < 20) begin
      step();
      guard++;
      checks++;
      if ({state, sec_left, walk_pending, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL walk_on_end held: got=%b want=%b",
                 {state, sec_left, walk_pending, tick}, exp_vec());
      end
    end
    walk_btn = 1'b0;
    checks++;
    if ({state, walk_pending} !== 4'b100_0 || guard !== 12) begin
      errors++;
      $display("FAIL walk_on_end exit: got state=%b pend=%b after %0d clk want 100/0 after 12",
               state, walk_pending, guard);
    end
  endtask

  task automatic test_async_reset();
    int guard, n;
    apply_reset("async_reset_a");
    sensor = 1'b1;
    guard = 0;
    while (state != 3'b101 && guard < 200) begin
      walk_btn = (state == 3'b100);
      step();
      guard++;
    end
    walk_btn = 1'b0;
    repeat (5) step();
    checks++;
    if ({state, walk_pending} !== 4'b101_1) begin
      errors++;
      $display("FAIL async_reset setup: got state=%b pend=%b want 101/1", state, walk_pending);
    end
    apply_reset("async_reset_b");
    n = 0;
    while (tick !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    // Release cycle is clk 1; tick must be high in clk 4, i.e. after 3 edges.
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL first_tick: got %0d edges want 3", n);
    end
  endtask

  task automatic test_sensor_ignored();
    int guard;
    apply_reset("sensor_ignored");
    guard = 0;
    while (state == 3'b000 && guard < 100) begin
      if (m_div == TD - 1 && m_cnt == dur[0] - 1) sensor = 1'b0;
      else sensor = 1'($urandom_range(0, 1));
      step();
      guard++;
      checks++;
      if ({state, sec_left, walk_pending, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL sensor_ignored cyc: got=%b want=%b",
                 {state, sec_left, walk_pending, tick}, exp_vec());
      end
    end
    sensor = 1'b0;
    checks++;
    if (state !== 3'b010) begin
      errors++;
      $display("FAIL sensor_ignored next: got %b want 010", state);
    end
  endtask

  task automatic test_random();
    apply_reset("random");
    for (int i = 0; i < 3000; i++) begin
      sensor = 1'($urandom_range(0, 1));
      walk_btn = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) apply_reset("random_rst");
      step();
      checks++;
      if ({state, sec_left, walk_pending, tick} !== exp_vec()) begin
        errors++;
        $display("FAIL random cycle %0d: got=%b want=%b", i,
                 {state, sec_left, walk_pending, tick}, exp_vec());
      end
    end
    sensor = 1'b0;
    walk_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_traffic();
    test_sensor_held();
    test_walk_served();
    test_walk_on_end();
    test_async_reset();
    test_sensor_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_state_seq.md
TRAFFIC_STATE_SEQ -- requirements
Module: traffic_state_seq

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, clk cycles per one-second tick (legal range >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port sensor, input, 1 bit, side-road traffic present (level, synchronous to clk).
REQ-005 The block SHALL have port walk_btn, input, 1 bit, pedestrian request (level or pulse, synchronous to clk).
REQ-006 The block SHALL have port state, output, 3 bits, current phase code, registered; it feeds the light decoder.
REQ-007 The block SHALL have port sec_left, output, 3 bits, seconds remaining in the current phase, registered.
REQ-008 The block SHALL have port walk_pending, output, 1 bit, latched walk request not yet served, registered.
REQ-009 The block SHALL have port tick, output, 1 bit, one-cycle pulse marking each second boundary.

Function
REQ-010 The block SHALL run a prescaler div counting 0..TICK_DIV-1, then wrapping to 0; tick is asserted for exactly the cycle in which div == TICK_DIV-1.
REQ-011 Each phase SHALL have a fixed duration in ticks: 000=6, 001=3, 010=6, 011=2, 100=6, 101=3, 110=2, 111=3.
REQ-012 A phase counter cnt SHALL be 0 on phase entry and increment on each tick; on the tick where cnt == duration-1 the phase ends, state updates on that same edge, and cnt returns to 0.
REQ-013 sec_left SHALL equal duration(state) - cnt at all times, so it is 6 immediately after entry to 000 and 1 during the final second.
REQ-014 Phase 000 (main green) SHALL transition to 001 if sensor = 1 at the ending tick, else to 010.
REQ-015 Phase 001 (main green, extension) and phase 010 (main green, long) SHALL transition to 011.
REQ-016 Phase 011 (main yellow) SHALL transition to 111 if walk_pending = 1 at the ending tick, else to 100.
REQ-017 Phase 100 (side green) SHALL transition to 101 if sensor = 1 at the ending tick, else to 110.
REQ-018 Phase 101 (side green, extension) SHALL transition to 110.
REQ-019 Phase 110 (side yellow) SHALL transition to 000.
REQ-020 Phase 111 (all red, walk) SHALL transition to 100.
REQ-021 sensor SHALL be sampled only on ending ticks of 000 and 100; changes at other times SHALL have no effect.
REQ-022 walk_pending SHALL be set in any cycle walk_btn = 1, and cleared on the edge that enters 111.
REQ-023 walk_btn presses while state = 111 SHALL be ignored; if a press coincides with the edge entering 111, the clear SHALL win.
REQ-024 A press on the same cycle as the 011 ending tick SHALL route to 111 (set and sample are the same cycle).
REQ-025 Each request SHALL be served at most once; multiple presses before service SHALL collapse into one 111 phase.
REQ-026 Any unreachable code SHALL NOT be possible; a default branch SHALL force state to 000 and cnt to 0.

Reset
REQ-027 While rst_n = 0, the block SHALL hold state = 000, cnt = 0, div = 0, sec_left = 6, walk_pending = 0, tick = 0, asynchronously and independent of clk.
REQ-028 After rst_n deasserts, the first tick SHALL occur TICK_DIV cycles later, and phase 000 SHALL last a full 6 ticks.
REQ-029 Reset asserted mid-phase, including in 111 or with walk_pending = 1, SHALL discard all progress and pending requests.

Verification (TICK_DIV=4)
REQ-030 Scenario 1: reset, sensor = 0, no walk -> state sequence 000(24 clk), 010(24), 011(8), 100(24), 110(8), 000; sec_left counts 6..1 in 000.
REQ-031 Scenario 2: sensor held at 1 -> sequence 000, 001(12 clk), 011, 100, 101(12 clk), 110, 000.
REQ-032 Scenario 3: one-cycle walk_btn during 000 -> walk_pending = 1 until the 011->111 edge; 111 lasts 12 clk, then 100, with walk_pending = 0.
REQ-033 Scenario 4: walk_btn pulsed on the 011 ending-tick cycle -> next state 111; a press held through all of 111 leaves walk_pending = 0 on the 111->100 edge.
REQ-034 Scenario 5: rst_n pulsed low asynchronously mid-101 -> state = 000, sec_left = 6, walk_pending = 0 immediately; the first tick occurs 4 clk after release.
REQ-035 Scenario 6: sensor toggles in 000 except at the ending tick, where sensor = 0 -> next state 010.
